alu_mult_sequencer: RTL and testbench

- Multi-cycle shift-add multiplier that has no adder of its own. It sequences the shared 32-bit ALU by driving the ALU ADD operation once per iteration.
- Sits beside the ALU in the execute stage and owns the ALU inputs while busy. Execute-stage muxing selects the sequencer's ALU drive whenever busy_o=1.
- Produces the low WIDTH bits of an unsigned product. Latency is variable, with early exit once the remaining multiplier bits are zero.

---
 rtl/alu_mult_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_mult_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_sequencer.sv
// Shift-add multiplier that borrows the shared execute-stage ALU for every add.
// Produces the low WIDTH bits of an unsigned product, exiting early once the multiplier bits run out.
module alu_mult_sequencer #(
    parameter int          WIDTH   = 32,
    parameter logic [3:0]  ADD_OP  = 4'b0011,
    parameter logic [3:0]  IDLE_OP = 4'b0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [WIDTH-1:0] multiplicand_i,
    input  logic [WIDTH-1:0] multiplier_i,
    input  logic [WIDTH-1:0] alu_data_i,
    output logic [3:0]       alu_operation_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int              CW         = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     count_q, count_d;
    logic [WIDTH-1:0]  product_q, product_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            acc_q     <= {WIDTH{1'b0}};
            mcand_q   <= {WIDTH{1'b0}};
            mplier_q  <= {WIDTH{1'b0}};
            count_q   <= {CW{1'b0}};
            product_q <= {WIDTH{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state, datapath update and ALU drive.
    always_comb begin
        state_d         = state_q;
        acc_d           = acc_q;
        mcand_d         = mcand_q;
        mplier_d        = mplier_q;
        count_d         = count_q;
        product_d       = product_q;
        alu_operation_o = IDLE_OP;
        alu_a_o         = {WIDTH{1'b0}};
        alu_b_o         = {WIDTH{1'b0}};

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mcand_d  = multiplicand_i;
                    mplier_d = multiplier_i;
                    acc_d    = {WIDTH{1'b0}};
                    count_d  = {CW{1'b0}};
                    state_d  = ST_CALC;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_CALC: begin
                alu_operation_o = ADD_OP;
                alu_a_o         = acc_q;
                alu_b_o         = mcand_q;
                if (mplier_q[0]) begin
                    acc_d = alu_data_i;
                end else begin
                    acc_d = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                // Product is captured on the edge into DONE so it is valid alongside done_o.
                if ((mplier_d == {WIDTH{1'b0}}) || (count_q == LAST_COUNT)) begin
                    state_d   = ST_DONE;
                    product_d = acc_d;
                end else begin
                    state_d   = ST_CALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Randomized and directed bench for alu_mult_sequencer, with a behavioural ALU and product/latency model.
module tb_alu_mult_sequencer;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [31:0] multiplicand_i;
    logic [31:0] multiplier_i;
    logic [31:0] alu_data_i;
    logic [3:0]  alu_operation_o;
    logic [31:0] alu_a_o;
    logic [31:0] alu_b_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] product_o;

    int total = 0;
    int bad   = 0;

    alu_mult_sequencer #(.WIDTH(32), .ADD_OP(4'b0011), .IDLE_OP(4'b0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .alu_data_i     (alu_data_i),
        .alu_operation_o(alu_operation_o),
        .alu_a_o        (alu_a_o),
        .alu_b_o        (alu_b_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .product_o      (product_o)
    );

    // Shared ALU: adds for op 0011, outputs zero for the idle op.
    assign alu_data_i = (alu_operation_o == 4'b0011) ? (alu_a_o + alu_b_o) : 32'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_product(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    function automatic int ref_latency(input logic [31:0] b);
        int k;
        k = 1;
        for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
        return k;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        multiplicand_i = a;
        multiplier_i   = b;
        start_i        = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Returns edges counted after the start edge until done_o is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        int e;
        e = 0;
        while (!done_o && e < 100) begin
            @(posedge clk);
            #1;
            e++;
        end
        lat = done_o ? e : -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start_i = 1'b0; multiplicand_i = 32'd0; multiplier_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy_o, done_o, product_o, alu_operation_o, alu_a_o, alu_b_o} !== 102'd0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b prod=%h op=%h a=%h b=%h want all 0",
                     busy_o, done_o, product_o, alu_operation_o, alu_a_o, alu_b_o);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_three_by_five();
        logic [31:0] exp_a [3] = '{32'd0, 32'd3, 32'd3};
        logic [31:0] exp_b [3] = '{32'd3, 32'd6, 32'd12};
        start_op(32'd3, 32'd5);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (alu_operation_o !== 4'b0011 || alu_a_o !== exp_a[i] || alu_b_o !== exp_b[i]) begin
                bad++;
                $display("FAIL alu_trace[%0d]: op=%h a=%0d b=%0d want op=3 a=%0d b=%0d",
                         i, alu_operation_o, alu_a_o, alu_b_o, exp_a[i], exp_b[i]);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (done_o !== 1'b1 || product_o !== 32'd15 || alu_operation_o !== 4'b0000 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL three_by_five_done: done=%b prod=%0d op=%h busy=%b want 1 15 0 1",
                     done_o, product_o, alu_operation_o, busy_o);
        end
        @(posedge clk);
        #1;
        total++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_width: done=%b busy=%b want 0 0", done_o, busy_o);
        end
    endtask

    task automatic check_mult(input string name, input logic [31:0] a, input logic [31:0] b);
        int lat;
        start_op(a, b);
        wait_done(lat);
        total++;
        if (lat !== ref_latency(b) || product_o !== ref_product(a, b)) begin
            bad++;
            $display("FAIL %s: %h*%h lat=%0d prod=%h want lat=%0d prod=%h",
                     name, a, b, lat, product_o, ref_latency(b), ref_product(a, b));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_boundaries();
        check_mult("times_zero", 32'h0000_1234, 32'd0);
        check_mult("max_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_mult("top_bit_only", 32'h0000_0003, 32'h8000_0000);
        check_mult("times_one", 32'hDEAD_BEEF, 32'd1);
    endtask

    task automatic test_start_held();
        int lat;
        start_op(32'd7, 32'd2);
        start_i = 1'b1;
        multiplicand_i = 32'd100;
        multiplier_i   = 32'd100;
        wait_done(lat);
        total++;
        if (lat !== 2 || product_o !== 32'd14) begin
            bad++;
            $display("FAIL start_held_first: lat=%0d prod=%0d want 2 14", lat, product_o);
        end
        @(posedge clk);
        #1;
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored_in_done: busy=%b want 0", busy_o);
        end
        @(posedge clk);
        #1;
        start_i = 1'b0;
        total++;
        if (busy_o !== 1'b1 || product_o !== 32'd14) begin
            bad++;
            $display("FAIL second_start_accept: busy=%b prod=%0d want 1 14", busy_o, product_o);
        end
        wait_done(lat);
        total++;
        if (lat !== ref_latency(32'd100) || product_o !== 32'd10000) begin
            bad++;
            $display("FAIL second_start_result: lat=%0d prod=%0d want %0d 10000",
                     lat, product_o, ref_latency(32'd100));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        start_op(32'h8000_0000, 32'h8000_0000);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if ({busy_o, done_o, product_o, alu_operation_o, alu_a_o, alu_b_o} !== 102'd0) begin
            bad++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b prod=%h op=%h a=%h b=%h want all 0",
                     busy_o, done_o, product_o, alu_operation_o, alu_a_o, alu_b_o);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done_o || busy_o) seen_done = 1'b1;
        end
        total++;
        if (seen_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_no_done: activity=%b want 0", seen_done);
        end
        check_mult("after_reset_6x7", 32'd6, 32'd7);
    endtask

    task automatic test_back_to_back();
        int lat;
        check_mult("b2b_9x9", 32'd9, 32'd9);
        total++;
        if (product_o !== 32'd81 || alu_operation_o !== 4'b0000) begin
            bad++;
            $display("FAIL b2b_idle_hold: prod=%0d op=%h want 81 0", product_o, alu_operation_o);
        end
        start_op(32'd2, 32'd3);
        total++;
        if (product_o !== 32'd81 || alu_operation_o !== 4'b0011) begin
            bad++;
            $display("FAIL b2b_calc_hold: prod=%0d op=%h want 81 3", product_o, alu_operation_o);
        end
        wait_done(lat);
        total++;
        if (lat !== 2 || product_o !== 32'd6 || alu_operation_o !== 4'b0000) begin
            bad++;
            $display("FAIL b2b_second: lat=%0d prod=%0d op=%h want 2 6 0", lat, product_o, alu_operation_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int n = 0; n < 25; n++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            check_mult("random", a, b);
        end
    endtask

    initial begin
        test_reset();
        test_three_by_five();
        test_boundaries();
        test_start_held();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
